// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
package stopwatch_pkg;

  // One BCD digit.
  typedef logic [3:0] bcd_t;

  // Largest legal tens-of-seconds digit and largest legal ones digit.
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t ONES_MAX     = 4'd9;

  // Run/pause state encoding.
  typedef enum logic {
    ST_PAUSED = 1'b0,
    ST_RUN    = 1'b1
  } sw_state_e;

endpackage : stopwatch_pkg

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that counts 00..WRAP and wraps back to 00.
// Clear beats increment. carry flags an increment that wraps this cycle.
module bcd_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int WRAP = 59
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output bcd_t tens,
  output bcd_t ones,
  output logic carry
);

  localparam bcd_t WRAP_TENS = bcd_t'(WRAP / 10);
  localparam bcd_t WRAP_ONES = bcd_t'(WRAP % 10);

  bcd_t tens_q, tens_d;
  bcd_t ones_q, ones_d;
  logic at_wrap;

  // Next-digit computation: clear, wrap to 00, ones rollover, or plain increment.
  always_comb begin
    tens_d  = tens_q;
    ones_d  = ones_q;
    at_wrap = (tens_q == WRAP_TENS) && (ones_q == WRAP_ONES);
    carry   = inc && !clr && at_wrap;
    if (clr) begin
      tens_d = '0;
      ones_d = '0;
    end else if (inc) begin
      if (at_wrap) begin
        tens_d = '0;
        ones_d = '0;
      end else if (ones_q == ONES_MAX) begin
        ones_d = '0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // Digit registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule : bcd_mod_counter

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping core: run/pause FSM, count/adjust muxing of the
// seconds and minutes BCD counters, and the registered wrap pulse.
//
// Handshake note: there is no valid/ready traffic here. Every input event is
// a single-cycle enable sampled at a rising edge; its effect appears on the
// registered outputs one cycle later.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int MIN_WRAP = 59
) (
  input  logic clk,
  input  logic rst,
  input  logic one_hz_tick,
  input  logic two_hz_tick,
  input  logic pause_p,
  input  logic clear_p,
  input  logic adj,
  input  logic sel,
  output bcd_t min_tens,
  output bcd_t min_ones,
  output bcd_t sec_tens,
  output bcd_t sec_ones,
  output logic running,
  output logic wrap_p
);

  localparam int SEC_WRAP = int'(SEC_TENS_MAX) * 10 + int'(ONES_MAX);

  sw_state_e state_q, state_d;
  logic      wrap_p_q, wrap_p_d;

  logic count_tick;
  logic adj_tick;
  logic sec_inc, min_inc;
  logic sec_carry, min_carry;

  // Mode muxing: the tick is judged against the current state, before any
  // pause toggle lands. Adjust mode advances one field with no carry.
  always_comb begin
    count_tick = !adj && (state_q == ST_RUN) && one_hz_tick;
    adj_tick   = adj && two_hz_tick;
    sec_inc    = count_tick || (adj_tick && sel);
    min_inc    = (count_tick && sec_carry) || (adj_tick && !sel);
    wrap_p_d   = count_tick && sec_carry && min_carry;
    state_d    = state_q;
    if (pause_p) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
    end
  end

  // Run/pause FSM and the wrap pulse register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_PAUSED;
      wrap_p_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wrap_p_q <= wrap_p_d;
    end
  end

  bcd_mod_counter #(.WRAP(SEC_WRAP)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .inc   (sec_inc),
    .clr   (clear_p),
    .tens  (sec_tens),
    .ones  (sec_ones),
    .carry (sec_carry)
  );

  bcd_mod_counter #(.WRAP(MIN_WRAP)) u_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (min_inc),
    .clr   (clear_p),
    .tens  (min_tens),
    .ones  (min_ones),
    .carry (min_carry)
  );

  assign running = (state_q == ST_RUN);
  assign wrap_p  = wrap_p_q;

endmodule : stopwatch_core

// File: doc/stopwatch_core.md
# stopwatch_core

Timekeeping core of the stopwatch: consumes the single-cycle tick enables produced by the clock divider and maintains an MM:SS count in BCD. Supports run/pause, clear, and a manual adjust mode that advances a selected field at the 2 Hz rate. Its four BCD digits feed the seven-segment display multiplexer.

## Interface
- `MIN_WRAP`, default 59: largest minute value (BCD 00–99); 59:59 wraps to 00:00 by default.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `one_hz_tick`  in  1  single-cycle enable at 1 Hz from the clock divider.
- `two_hz_tick`  in  1  single-cycle enable at 2 Hz from the clock divider.
- `pause_p`  in  1  debounced single-cycle pulse; toggles run/pause.
- `clear_p`  in  1  debounced single-cycle pulse; zeroes the count.
- `adj`  in  1  level; 1 selects adjust mode.
- `sel`  in  1  level; field to adjust: 0 = minutes, 1 = seconds.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  BCD digits, registered.
- `running`  out  1  1 while in RUN.
- `wrap_p`  out  1  single-cycle pulse when the count wraps from MIN_WRAP:59 to 00:00.

## Operation
- State machine with two states:
  - PAUSED: reset state.
  - RUN.
  - `pause_p` toggles between them in any mode.
- Count mode (`adj`=0, RUN), on each `one_hz_tick`:
  - Seconds increment.
  - sec_ones 9→0 carries into sec_tens; sec_tens 5 with ones 9 → 00 carries into minutes.
  - Minutes increment the same way up to MIN_WRAP.
  - At MIN_WRAP:59 the count goes to 00:00 and `wrap_p` asserts.
- Count mode while PAUSED: ticks are ignored.
- Adjust mode (`adj`=1), in either state:
  - `one_hz_tick` is ignored.
  - On each `two_hz_tick`, only the field chosen by `sel` increments.
  - Seconds wrap 59→00; minutes wrap MIN_WRAP→00.
  - No carry between fields and no `wrap_p`.
- `clear_p` sets all digits to 0. It does not change the run state.
- Priority within one cycle:
  - `clear_p` beats any increment; a tick in the same cycle is discarded.
  - `pause_p` together with a tick: the tick is evaluated against the state before the toggle.
    - RUN + tick + `pause_p`: the increment happens and the next state is PAUSED.
    - PAUSED + tick + `pause_p`: no increment; the next state is RUN.
- `adj` and `sel` are sampled in the same cycle as the tick. Changing them between ticks has no side effect.
- Digits never leave the legal BCD range. Ones digits are 0–9; sec_tens is 0–5.

## Timing
- Reset (`rst`=0 at an edge):
  - All digits 0, `running`=0, `wrap_p`=0, state PAUSED.
  - Reset mid-count discards the count in that same cycle.
- Latency: a tick or pulse sampled at edge N is reflected on the outputs after edge N, i.e. one cycle.
- `running` changes in the cycle after `pause_p`.
- `wrap_p` is high for exactly the one cycle in which the digits first read 00:00 after a wrap.
- Input tick and pulse signals are assumed to be single-cycle. A pulse held high for k cycles acts as k events. This is the upstream debouncer's responsibility.
- No combinational path from any input to any output.

## Structure
- Shared package `stopwatch_pkg`:
  - BCD digit type (4 bits).
  - Constants `SEC_TENS_MAX`=5 and `ONES_MAX`=9.
  - State encoding for RUN/PAUSED.
- Sub-module `bcd_mod_counter`: a two-digit BCD counter.
  - Parameter: wrap value.
  - Inputs: `inc`, `clr`.
  - Output: `carry`, a combinational wrap indicator.
  - Instantiated twice: seconds with wrap value 59, minutes with MIN_WRAP.
- Top level holds the FSM, the mode and priority muxing of `inc`/`clr`, and the `wrap_p` register.

## Test plan
- Reset then `pause_p` gives RUN. 75 `one_hz_tick`s → digits 01:15, `running`=1.
- Preload 59:58 via adjust, return to count mode, apply 2 ticks → 59:59, then 00:00 with `wrap_p` high for exactly 1 cycle.
- In PAUSED at 00:10, apply 5 ticks → still 00:10. `pause_p` and a tick in the same cycle → 00:10 and `running`=1. Next tick → 00:11.
- `adj`=1, `sel`=1 at 00:58, three `two_hz_tick`s plus interleaved `one_hz_tick`s → 00:01 with minutes unchanged. `sel`=0 at 59:xx, one `two_hz_tick` → 00:xx.
- RUN at 12:34, `clear_p` in the same cycle as a tick → 00:00 with `running` still 1. Next tick → 00:01.
- `rst` low for 1 cycle mid-count at 07:07 in RUN → 00:00, `running`=0. Subsequent ticks are ignored until `pause_p`.
